// File: rtl/pll_mode_pkg.sv
// Shared types and constants for the rPLL mode sequencer.
//   pll_state_t : sequencer FSM states
//   pll_sel_t   : dynamic select triple driven to the rPLL (IDSEL/FBDSEL/ODSEL)
//   mode_sel()  : maps a 2-bit mode index to the select triple
package pll_mode_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } pll_state_t;

  typedef struct packed {
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [5:0] odsel;
  } pll_sel_t;

  // Static divider encodings for a 27 MHz reference:
  // fout = 27 * (FBDIV+1) / (IDIV+1), ODIV chosen to keep VCO in range.
  // mode0 640x480   25.2  MHz
  localparam logic [5:0] MODE0_IDIV  = 6'd14;
  localparam logic [5:0] MODE0_FBDIV = 6'd13;
  localparam logic [5:0] MODE0_ODIV  = 6'd32;
  // mode1 800x600   40    MHz
  localparam logic [5:0] MODE1_IDIV  = 6'd26;
  localparam logic [5:0] MODE1_FBDIV = 6'd39;
  localparam logic [5:0] MODE1_ODIV  = 6'd16;
  // mode2 1024x768  64.8  MHz (closest to 65 MHz)
  localparam logic [5:0] MODE2_IDIV  = 6'd4;
  localparam logic [5:0] MODE2_FBDIV = 6'd11;
  localparam logic [5:0] MODE2_ODIV  = 6'd8;
  // mode3 1280x720  74.25 MHz
  localparam logic [5:0] MODE3_IDIV  = 6'd3;
  localparam logic [5:0] MODE3_FBDIV = 6'd10;
  localparam logic [5:0] MODE3_ODIV  = 6'd8;

  // The rPLL dynamic select inputs take the one's complement of the
  // static encoding.
  function automatic pll_sel_t mode_sel(input logic [1:0] mode);
    logic [17:0] raw;
    raw = '0;
    case (mode)
      2'd0: raw = {MODE0_IDIV, MODE0_FBDIV, MODE0_ODIV};
      2'd1: raw = {MODE1_IDIV, MODE1_FBDIV, MODE1_ODIV};
      2'd2: raw = {MODE2_IDIV, MODE2_FBDIV, MODE2_ODIV};
      default: raw = {MODE3_IDIV, MODE3_FBDIV, MODE3_ODIV};
    endcase
    return pll_sel_t'(~raw);
  endfunction

endpackage

// File: rtl/pll_mode_sequencer_lock_sync_debounce.sv
// Lock synchroniser and debouncer.
//   clk, rst_n   : sys clock, async active-low reset
//   lock_async   : raw rPLL LOCK
//   clr          : hold the consecutive-high counter at zero
//   lock_s       : LOCK after a 2-FF synchroniser
//   stable       : lock_s high and this is the STABLE_CYCLES-th consecutive
//                  high cycle since clr dropped
module lock_sync_debounce #(
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lock_async,
  input  logic clr,
  output logic lock_s,
  output logic stable
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= lock_async;
      sync2 <= sync1;
      if (clr || !sync2) begin
        cnt <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign lock_s = sync2;
  assign stable = sync2 && (cnt == CNT_LAST);

endmodule

// File: rtl/pll_mode_sequencer.sv
// Gowin rPLL mode sequencer running on the free-running OSC clock.
//   sys_clk, sys_rst_n            : clock, async active-low reset
//   mode_req_valid/id/ready       : mode-change request handshake
//   pll_lock                      : rPLL LOCK (asynchronous)
//   pll_reset                     : rPLL RESET
//   pll_idsel/fbdsel/odsel        : rPLL dynamic divider selects
//   pix_rst_n                     : pixel-domain reset, released only in RUN
//   mode_active                   : mode currently programmed
//   status_locked / status_fail   : high in RUN / FAIL respectively
module pll_mode_sequencer
  import pll_mode_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned BOOT_MODE           = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       mode_req_valid,
  input  logic [1:0] mode_req_id,
  output logic       mode_req_ready,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       pix_rst_n,
  output logic [1:0] mode_active,
  output logic       status_locked,
  output logic       status_fail
);

  localparam int unsigned HW = $clog2(RESET_HOLD_CYCLES) + 1;
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
  localparam int unsigned RW = $clog2(MAX_RETRIES) + 1;

  localparam logic [HW-1:0] HOLD_LAST  = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);
  localparam logic [1:0]    BOOT_IDX   = 2'(BOOT_MODE);

  pll_state_t    state;
  pll_sel_t      sel;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] to_cnt;
  logic [RW-1:0] retry_cnt;

  logic          lock_s;
  logic          stable_hit;
  logic          accept;
  logic          go_hold;
  logic [1:0]    hold_mode;

  lock_sync_debounce #(
    .STABLE_CYCLES(LOCK_STABLE_CYCLES)
  ) u_lock (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .lock_async(pll_lock),
    .clr       (state != ST_STABLE),
    .lock_s    (lock_s),
    .stable    (stable_hit)
  );

  assign accept     = mode_req_valid && mode_req_ready;
  assign pll_idsel  = sel.idsel;
  assign pll_fbdsel = sel.fbdsel;
  assign pll_odsel  = sel.odsel;

  // Every path back into HOLD is collected here so the selects, counters
  // and outputs are reloaded in exactly one place. An accepted request
  // takes priority over lock loss in RUN.
  always_comb begin
    go_hold   = 1'b0;
    hold_mode = mode_active;
    case (state)
      ST_WAIT: begin
        if (!lock_s && (to_cnt == TO_LAST) && (retry_cnt != RETRY_LAST)) begin
          go_hold = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept) begin
          go_hold   = 1'b1;
          hold_mode = mode_req_id;
        end else if (!lock_s) begin
          go_hold = 1'b1;
        end
      end
      ST_FAIL: begin
        if (accept) begin
          go_hold   = 1'b1;
          hold_mode = mode_req_id;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= ST_HOLD;
      pll_reset      <= 1'b1;
      pix_rst_n      <= 1'b0;
      mode_req_ready <= 1'b0;
      status_locked  <= 1'b0;
      status_fail    <= 1'b0;
      mode_active    <= BOOT_IDX;
      sel            <= mode_sel(BOOT_IDX);
      hold_cnt       <= '0;
      to_cnt         <= '0;
      retry_cnt      <= '0;
    end else if (go_hold) begin
      state          <= ST_HOLD;
      pll_reset      <= 1'b1;
      pix_rst_n      <= 1'b0;
      mode_req_ready <= 1'b0;
      status_locked  <= 1'b0;
      status_fail    <= 1'b0;
      mode_active    <= hold_mode;
      sel            <= mode_sel(hold_mode);
      hold_cnt       <= '0;
      to_cnt         <= '0;
      if (state == ST_WAIT) begin
        retry_cnt <= retry_cnt + RW'(1);
      end else if (accept) begin
        retry_cnt <= '0;
      end
    end else begin
      case (state)
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= ST_WAIT;
            pll_reset <= 1'b0;
            hold_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_WAIT: begin
          if (lock_s) begin
            state  <= ST_STABLE;
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            // Timeouts with retries left were taken by go_hold, so this is
            // the final failed attempt.
            state          <= ST_FAIL;
            retry_cnt      <= retry_cnt + RW'(1);
            to_cnt         <= '0;
            pll_reset      <= 1'b1;
            status_fail    <= 1'b1;
            mode_req_ready <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state  <= ST_WAIT;
            to_cnt <= '0;
          end else if (stable_hit) begin
            state          <= ST_RUN;
            retry_cnt      <= '0;
            pix_rst_n      <= 1'b1;
            status_locked  <= 1'b1;
            mode_req_ready <= 1'b1;
          end
        end
        ST_RUN, ST_FAIL: ;
        default: begin
          state     <= ST_HOLD;
          pll_reset <= 1'b1;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_mode_sequencer.sv
module tb_pll_mode_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       mode_req_valid = 1'b0;
  logic [1:0] mode_req_id = 2'd0;
  logic       mode_req_ready;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel;
  logic [5:0] pll_fbdsel;
  logic [5:0] pll_odsel;
  logic       pix_rst_n;
  logic [1:0] mode_active;
  logic       status_locked;
  logic       status_fail;

  pll_mode_sequencer #(
    .RESET_HOLD_CYCLES  (16),
    .LOCK_STABLE_CYCLES (1024),
    .LOCK_TIMEOUT_CYCLES(64),
    .MAX_RETRIES        (3),
    .BOOT_MODE          (0)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .mode_req_valid(mode_req_valid),
    .mode_req_id   (mode_req_id),
    .mode_req_ready(mode_req_ready),
    .pll_lock      (pll_lock),
    .pll_reset     (pll_reset),
    .pll_idsel     (pll_idsel),
    .pll_fbdsel    (pll_fbdsel),
    .pll_odsel     (pll_odsel),
    .pix_rst_n     (pix_rst_n),
    .mode_active   (mode_active),
    .status_locked (status_locked),
    .status_fail   (status_fail)
  );

  always #5 sys_clk = ~sys_clk;

  // PLL model: locks lock_delay cycles after RESET falls, when enabled.
  int   lock_delay = 50;
  bit   lock_en    = 1'b1;
  bit   force_low  = 1'b0;
  int   mcnt       = 0;
  logic model_lk   = 1'b0;

  always @(negedge sys_clk) begin
    if (pll_reset !== 1'b0) begin
      mcnt     <= 0;
      model_lk <= 1'b0;
    end else begin
      if (mcnt < 100000) mcnt <= mcnt + 1;
      model_lk <= lock_en && ((mcnt + 1) >= lock_delay);
    end
  end

  assign pll_lock = model_lk & ~force_low;

  // Scoreboard
  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   rst_falls = 0;
  int   rst_high = 0;

  function automatic logic [17:0] sel_exp(input int m);
    logic [5:0] id, fb, od;
    case (m)
      0: begin id = 6'd14; fb = 6'd13; od = 6'd32; end
      1: begin id = 6'd26; fb = 6'd39; od = 6'd16; end
      2: begin id = 6'd4;  fb = 6'd11; od = 6'd8;  end
      default: begin id = 6'd3; fb = 6'd10; od = 6'd8; end
    endcase
    return ~{id, fb, od};
  endfunction

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic snap_push(input string p, input logic pr, input logic px,
                           input logic rdy, input logic lk, input logic fl,
                           input int m);
    push({p, "_pll_reset"}, 32'(pr));
    push({p, "_pix_rst_n"}, 32'(px));
    push({p, "_ready"},     32'(rdy));
    push({p, "_locked"},    32'(lk));
    push({p, "_fail"},      32'(fl));
    push({p, "_mode"},      32'(m));
    push({p, "_sel"},       32'(sel_exp(m)));
  endtask

  task automatic snap_pop();
    pop_chk(32'(pll_reset));
    pop_chk(32'(pix_rst_n));
    pop_chk(32'(mode_req_ready));
    pop_chk(32'(status_locked));
    pop_chk(32'(status_fail));
    pop_chk(32'(mode_active));
    pop_chk(32'({pll_idsel, pll_fbdsel, pll_odsel}));
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return pix_rst_n;
      1: return pll_lock;
      2: return status_fail;
      default: return pll_reset;
    endcase
  endfunction

  // Bounded wait: n is the number of ticks taken (== max on expiry).
  task automatic wait_sig(input int which, input logic level, input int max,
                          output int n);
    logic prev;
    prev      = pll_reset;
    rst_falls = 0;
    rst_high  = 0;
    n         = 0;
    do begin
      tick();
      n++;
      if (prev === 1'b1 && pll_reset === 1'b0) rst_falls++;
      if (pll_reset === 1'b1) rst_high++;
      prev = pll_reset;
    end while (sig(which) !== level && n < max);
  endtask

  initial begin
    int n;

    // Reset values
    #1 sys_rst_n = 1'b0;
    repeat (3) tick();
    snap_push("reset", 1, 0, 0, 0, 0, 0);
    snap_pop();

    // Boot: 16-cycle PLL reset, then lock + 2 sync + 1024 stable + register
    sys_rst_n = 1'b1;
    push("boot_reset_hold", 16);
    wait_sig(3, 1'b0, 100, n);
    pop_chk(n);
    push("boot_lock_to_run", 1027);
    wait_sig(1, 1'b1, 200, n);
    wait_sig(0, 1'b1, 2000, n);
    pop_chk(n);
    snap_push("boot_run", 0, 1, 1, 1, 0, 0);
    snap_pop();

    // Mode 2 request from RUN
    push("req2_ready", 1);
    pop_chk(32'(mode_req_ready));
    mode_req_valid = 1'b1;
    mode_req_id    = 2'd2;
    snap_push("req2_accept", 1, 0, 0, 0, 0, 2);
    tick();
    mode_req_valid = 1'b0;
    snap_pop();
    push("req2_lock_to_run", 1027);
    wait_sig(1, 1'b1, 200, n);
    wait_sig(0, 1'b1, 2000, n);
    pop_chk(n);
    snap_push("req2_run", 0, 1, 1, 1, 0, 2);
    snap_pop();

    // Lock glitch at stable count ~500 while relocking to mode 3
    mode_req_valid = 1'b1;
    mode_req_id    = 2'd3;
    tick();
    mode_req_valid = 1'b0;
    wait_sig(1, 1'b1, 200, n);
    repeat (503) tick();
    force_low = 1'b1;
    repeat (3) tick();
    force_low = 1'b0;
    push("glitch_recount", 1027);
    push("glitch_no_hold", 0);
    wait_sig(0, 1'b1, 2000, n);
    pop_chk(n);
    pop_chk(rst_high);
    snap_push("glitch_run", 0, 1, 1, 1, 0, 3);
    snap_pop();

    // PLL never locks: three 16+64 attempts, then FAIL
    lock_en        = 1'b0;
    mode_req_valid = 1'b1;
    mode_req_id    = 2'd0;
    tick();
    mode_req_valid = 1'b0;
    push("nolock_time_to_fail", 240);
    push("nolock_attempts", 3);
    wait_sig(2, 1'b1, 600, n);
    pop_chk(n);
    pop_chk(rst_falls);
    snap_push("fail", 1, 0, 1, 0, 1, 0);
    snap_pop();

    // Recover from FAIL with a mode 1 request
    lock_en        = 1'b1;
    mode_req_valid = 1'b1;
    mode_req_id    = 2'd1;
    snap_push("fail_accept", 1, 0, 0, 0, 0, 1);
    tick();
    mode_req_valid = 1'b0;
    snap_pop();
    wait_sig(0, 1'b1, 3000, n);
    snap_push("recover_run", 0, 1, 1, 1, 0, 1);
    snap_pop();

    // Lock drop in RUN: pix_rst_n low 3 cycles later, relock same mode
    force_low = 1'b1;
    push("drop_pix_latency", 3);
    wait_sig(0, 1'b0, 10, n);
    pop_chk(n);
    force_low = 1'b0;
    snap_push("drop_hold", 1, 0, 0, 0, 0, 1);
    snap_pop();
    wait_sig(0, 1'b1, 3000, n);
    snap_push("drop_relock", 0, 1, 1, 1, 0, 1);
    snap_pop();

    // Lock loss and request at the same edge: request wins
    force_low = 1'b1;
    tick();
    tick();
    mode_req_valid = 1'b1;
    mode_req_id    = 2'd2;
    snap_push("coincide", 1, 0, 0, 0, 0, 2);
    tick();
    mode_req_valid = 1'b0;
    force_low      = 1'b0;
    snap_pop();
    wait_sig(0, 1'b1, 3000, n);
    snap_push("coincide_run", 0, 1, 1, 1, 0, 2);
    snap_pop();

    // Asynchronous reset in STABLE
    mode_req_valid = 1'b1;
    mode_req_id    = 2'd3;
    tick();
    mode_req_valid = 1'b0;
    wait_sig(1, 1'b1, 200, n);
    repeat (100) tick();
    snap_push("pre_rst_stable", 0, 0, 0, 0, 0, 3);
    snap_pop();
    #2 sys_rst_n = 1'b0;
    #1;
    snap_push("async_rst", 1, 0, 0, 0, 0, 0);
    snap_pop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
